// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the FPGA<->ESP8266 UART link stages.
//   Provides the default frame geometry, the receiver/transmitter state
//   encoding and a helper that sizes counters from their terminal count.
// ---------------------------------------------------------------------------
package uart_pkg;

  // Default frame geometry: 8 data bits, 16 oversample ticks per bit.
  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_OVERSAMPLE = 16;

  // State encoding, shared with the transmitter so traces read the same.
  localparam logic [1:0] UART_IDLE  = 2'd0;
  localparam logic [1:0] UART_START = 2'd1;
  localparam logic [1:0] UART_DATA  = 2'd2;
  localparam logic [1:0] UART_STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = UART_IDLE,
    ST_START = UART_START,
    ST_DATA  = UART_DATA,
    ST_STOP  = UART_STOP
  } uart_state_e;

  // Width of a counter that must hold the values 0..n-1 (never below 1 bit).
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
//   Brings the asynchronous serial line into the clk domain and detects the
//   falling edge that marks a possible start bit.
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset; all flops reset to 1 so a
//                 released reset never looks like a start edge
//     rx_in  in   raw serial line, idle high
//     rx_s   out  synchronised line (two flops after rx_in)
//     fall_s out  one-cycle pulse when rx_s goes 1 -> 0
// ---------------------------------------------------------------------------
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic rx_s,
  output logic fall_s
);

  // Stages 0 and 1 form the synchroniser; stage 2 is the previous value of
  // the synchronised line, used only for edge detection.
  localparam int STAGES = 3;

  logic [STAGES-1:0] chain_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_chain
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            chain_reg[gi] <= 1'b1;
          end else begin
            chain_reg[gi] <= rx_in;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            chain_reg[gi] <= 1'b1;
          end else begin
            chain_reg[gi] <= chain_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign rx_s   = chain_reg[1];
  assign fall_s = chain_reg[2] & ~chain_reg[1];

endmodule

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   Receive side of the FPGA<->ESP8266 UART link. Oversamples the serial line
//   with the baud generator's tick enable, deserialises 8N1-style frames
//   (LSB first) and hands each word over with a valid/ack handshake.
//   Parameters:
//     DATA_WIDTH  data bits per frame (5..9)
//     OVERSAMPLE  ticks per bit period (even, >= 8)
//   Ports:
//     CLK          in   system clock
//     RST          in   asynchronous active-low reset
//     BCLK         in   oversample tick, one CLK wide, OVERSAMPLE x baud
//     RX_IN        in   serial line, idle high, asynchronous to CLK
//     rx_ack       in   consumer took rx_data; clears rx_valid
//     rx_data      out  last accepted word, stable while rx_valid=1
//     rx_valid     out  word available, held until rx_ack
//     rx_busy      out  frame in progress
//     frame_error  out  one-cycle pulse: stop bit sampled low
//     rx_overrun   out  one-cycle pulse: word completed while rx_valid=1
// ---------------------------------------------------------------------------
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BCLK,
  input  logic                  RX_IN,
  input  logic                  rx_ack,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_busy,
  output logic                  frame_error,
  output logic                  rx_overrun
);

  localparam int TW = cnt_width(OVERSAMPLE);
  localparam int BW = cnt_width(DATA_WIDTH);

  // START samples half a bit after the edge; DATA and STOP then sample one
  // full bit period apart, which lands each sample mid-bit.
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  // ---------------------------------------------------------------------
  // Input synchroniser and start-edge detect
  // ---------------------------------------------------------------------
  logic rx_s;
  logic fall_s;

  uart_rx_sync u_sync (
    .clk    (CLK),
    .rst_n  (RST),
    .rx_in  (RX_IN),
    .rx_s   (rx_s),
    .fall_s (fall_s)
  );

  // ---------------------------------------------------------------------
  // Frame FSM, counters and shift register
  // ---------------------------------------------------------------------
  uart_state_e           state_reg,    state_next;
  logic [TW-1:0]         tick_cnt_reg, tick_cnt_next;
  logic [BW-1:0]         bit_cnt_reg,  bit_cnt_next;
  logic [DATA_WIDTH-1:0] shift_reg,    shift_next;
  logic                  stop_ok;
  logic                  stop_bad;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= ST_IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    stop_ok       = 1'b0;
    stop_bad      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // The edge detector only fires on a 1->0 transition, so a line
        // held low after a break cannot restart a frame until it has gone
        // high again.
        if (fall_s) begin
          state_next    = ST_START;
          tick_cnt_next = '0;
        end
      end

      ST_START: begin
        if (BCLK) begin
          if (tick_cnt_reg == TICK_HALF) begin
            if (rx_s) begin
              // Line back high mid start bit: treat as a glitch, silently.
              state_next = ST_IDLE;
            end else begin
              state_next    = ST_DATA;
              tick_cnt_next = '0;
              bit_cnt_next  = '0;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (BCLK) begin
          if (tick_cnt_reg == TICK_FULL) begin
            // LSB arrives first: shift in at the top so that after
            // DATA_WIDTH samples the first bit sits at bit 0.
            shift_next    = {rx_s, shift_reg[DATA_WIDTH-1:1]};
            tick_cnt_next = '0;
            if (bit_cnt_reg == BIT_LAST) begin
              state_next = ST_STOP;
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (BCLK) begin
          if (tick_cnt_reg == TICK_FULL) begin
            // Leave at mid stop bit so a back-to-back start edge that
            // follows a short stop bit is not missed.
            state_next    = ST_IDLE;
            tick_cnt_next = '0;
            if (rx_s) begin
              stop_ok = 1'b1;
            end else begin
              stop_bad = 1'b1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next    = ST_IDLE;
        tick_cnt_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output handshake
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rx_data_reg,     rx_data_next;
  logic                  rx_valid_reg,    rx_valid_next;
  logic                  frame_error_reg, frame_error_next;
  logic                  rx_overrun_reg,  rx_overrun_next;

  always_comb begin
    rx_data_next     = rx_data_reg;
    rx_valid_next    = rx_valid_reg;
    frame_error_next = stop_bad;
    rx_overrun_next  = 1'b0;

    if (stop_ok) begin
      // An ack arriving together with a new word frees the holding
      // register in the same cycle, so the new word takes its place.
      if (!rx_valid_reg || rx_ack) begin
        rx_data_next  = shift_reg;
        rx_valid_next = 1'b1;
      end else begin
        rx_overrun_next = 1'b1;
      end
    end else if (rx_ack) begin
      rx_valid_next = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      frame_error_reg <= 1'b0;
      rx_overrun_reg  <= 1'b0;
    end else begin
      rx_data_reg     <= rx_data_next;
      rx_valid_reg    <= rx_valid_next;
      frame_error_reg <= frame_error_next;
      rx_overrun_reg  <= rx_overrun_next;
    end
  end

  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign frame_error = frame_error_reg;
  assign rx_overrun  = rx_overrun_reg;
  assign rx_busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// Bench for uart_receiver: 50 MHz clock, BCLK every N clocks, a serial
// transmitter model driving RX_IN, and an event-level model of what the
// consumer must see (words, framing errors, overruns, ack-driven clears).
module tb_uart_receiver;

  localparam int N   = 4;        // clocks per oversample tick
  localparam int BIT = 16 * N;   // nominal clocks per bit

  localparam int EV_LOAD = 1;
  localparam int EV_FERR = 2;
  localparam int EV_OVR  = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       BCLK = 1'b0;
  logic       RX_IN = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_error;
  logic       rx_overrun;

  uart_receiver #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .BCLK        (BCLK),
    .RX_IN       (RX_IN),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_busy     (rx_busy),
    .frame_error (frame_error),
    .rx_overrun  (rx_overrun)
  );

  always #10 CLK = ~CLK;

  // Tick generator: BCLK changes just after a rising edge, so the value seen
  // at a rising edge is the one the DUT samples there.
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge CLK);
      #1;
      BCLK = (div == N - 1);
      div  = (div + 1) % N;
    end
  end

  // ---------------------------------------------------------------------
  // Counters and model
  // ---------------------------------------------------------------------
  int         total = 0;
  int         bad = 0;
  int         fe_cnt = 0;
  int         ovr_cnt = 0;
  logic       model_valid = 1'b0;
  logic [7:0] model_data = 8'h00;
  bit         ack_pending = 1'b0;
  int         exp_q[$];          // kind*256 + data, in arrival order
  int         lat;
  int         busy_cycles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic expect_event(input int kind, input logic [7:0] d, input string name);
    int e;
    if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, kind * 256 + int'(d), 0);
    end else begin
      e = exp_q.pop_front();
      check(name, kind * 256 + int'(d), e);
    end
  endtask

  // What a completed frame must produce for the consumer.
  task automatic model_frame(input logic [7:0] d, input logic stop_bit);
    if (!stop_bit) begin
      exp_q.push_back(EV_FERR * 256);
    end else if (!model_valid) begin
      exp_q.push_back(EV_LOAD * 256 + int'(d));
      model_valid = 1'b1;
      model_data  = d;
    end else begin
      exp_q.push_back(EV_OVR * 256);
    end
  endtask

  // ---------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------
  logic       prev_valid = 1'b0;
  logic       prev_fe = 1'b0;
  logic       prev_ovr = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge CLK) begin
    if (!RST) begin
      check("reset_outputs", {20'd0, rx_data, rx_valid, rx_busy, frame_error, rx_overrun}, 32'd0);
      prev_valid = 1'b0;
      prev_fe    = 1'b0;
      prev_ovr   = 1'b0;
      prev_data  = 8'h00;
    end else begin
      if (frame_error) begin
        fe_cnt++;
        check("fe_single_pulse", prev_fe, 0);
        expect_event(EV_FERR, 8'h00, "fe_event");
      end
      if (rx_overrun) begin
        ovr_cnt++;
        check("ovr_single_pulse", prev_ovr, 0);
        expect_event(EV_OVR, 8'h00, "ovr_event");
      end
      if (rx_valid && (!prev_valid || rx_data !== prev_data)) begin
        expect_event(EV_LOAD, rx_data, "word");
      end
      if (!rx_valid && prev_valid) begin
        check("valid_clear_by_ack", ack_pending, 1);
        ack_pending = 1'b0;
      end
      prev_valid = rx_valid;
      prev_fe    = frame_error;
      prev_ovr   = rx_overrun;
      prev_data  = rx_data;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic drive_bit(input logic v, input int len);
    @(posedge CLK);
    #1 RX_IN = v;
    repeat (len - 1) @(posedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int len,
                            input bit use_model);
    if (use_model) model_frame(d, stop_bit);
    drive_bit(1'b0, len);
    for (int i = 0; i < 8; i++) drive_bit(d[i], len);
    drive_bit(stop_bit, len);
    drive_bit(1'b1, 2 * len);
  endtask

  task automatic do_ack();
    @(posedge CLK);
    #1;
    rx_ack      = 1'b1;
    ack_pending = 1'b1;
    model_valid = 1'b0;
    @(posedge CLK);
    #1 rx_ack = 1'b0;
  endtask

  task automatic checkpoint(input string name);
    repeat (4) @(negedge CLK);
    check({name, "_pending_events"}, exp_q.size(), 0);
    check({name, "_valid"}, rx_valid, model_valid);
    if (model_valid) check({name, "_data"}, rx_data, model_data);
    check({name, "_busy"}, rx_busy, 0);
    check({name, "_ack_done"}, ack_pending, 0);
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    repeat (5) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (20) @(posedge CLK);

    // 1: single word, no ack; valid about 9.5 bit times after the edge
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1, BIT, 1'b1);
      begin
        for (int i = 0; i < 1200; i++) begin
          @(posedge CLK);
          #2;
          if (rx_valid && lat < 0) lat = i;
        end
      end
    join
    check("t1_latency_in_window", (lat >= 600 && lat <= 625), 1);
    checkpoint("t1");
    check("t1_data_literal", rx_data, 8'hA5);
    check("t1_no_frame_error", fe_cnt, 0);
    do_ack();
    checkpoint("t1_acked");

    // 2: overrun keeps the first word; after ack the next word loads
    send_frame(8'h3C, 1'b1, BIT, 1'b1);
    send_frame(8'hC3, 1'b1, BIT, 1'b1);
    checkpoint("t2_overrun");
    check("t2_data_kept_literal", rx_data, 8'h3C);
    check("t2_one_overrun", ovr_cnt, 1);
    do_ack();
    send_frame(8'h0F, 1'b1, BIT, 1'b1);
    checkpoint("t2_after_ack");
    check("t2_data_literal", rx_data, 8'h0F);
    check("t2_no_more_overrun", ovr_cnt, 1);
    do_ack();

    // 3: bad stop bit, then a good word, then a break
    send_frame(8'h55, 1'b0, BIT, 1'b1);
    checkpoint("t3_ferr");
    check("t3_one_frame_error", fe_cnt, 1);
    check("t3_valid_low_literal", rx_valid, 0);
    send_frame(8'h81, 1'b1, BIT, 1'b1);
    checkpoint("t3_good");
    check("t3_data_literal", rx_data, 8'h81);
    do_ack();
    exp_q.push_back(EV_FERR * 256);
    drive_bit(1'b0, 30 * BIT);
    drive_bit(1'b1, 2 * BIT);
    checkpoint("t3_break");
    check("t3_break_single_ferr", fe_cnt, 2);

    // 4: 3-tick low glitch on an idle line
    busy_cycles = 0;
    fork
      begin
        drive_bit(1'b0, 3 * N);
        drive_bit(1'b1, 1);
      end
      begin
        repeat (100) begin
          @(negedge CLK);
          if (rx_busy) busy_cycles++;
        end
      end
    join
    check("t4_busy_only_in_start", (busy_cycles >= 20 && busy_cycles <= 40), 1);
    checkpoint("t4_glitch");

    // 5: reset in the middle of the data bits, then a clean frame
    drive_bit(1'b0, BIT);
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT);
    drive_bit(1'b1, BIT / 2);
    @(posedge CLK);
    #1;
    RST   = 1'b0;
    RX_IN = 1'b1;
    model_valid = 1'b0;
    model_data  = 8'h00;
    exp_q.delete();
    ack_pending = 1'b0;
    repeat (10) @(negedge CLK);
    check("t5_busy_in_reset_literal", rx_busy, 0);
    @(posedge CLK);
    #1 RST = 1'b1;
    repeat (2 * BIT) @(posedge CLK);
    send_frame(8'h7E, 1'b1, BIT, 1'b1);
    checkpoint("t5_after_reset");
    check("t5_data_literal", rx_data, 8'h7E);

    // 6: ack lands on the very cycle the next word is accepted. The stop
    //    sample is the 152nd tick (8 + 8*16 + 16) after the FSM leaves idle,
    //    which happens three clocks after the line is driven low.
    exp_q.push_back(EV_LOAD * 256 + 8'h96);
    model_data = 8'h96;
    fork
      send_frame(8'h96, 1'b1, BIT, 1'b0);
      begin
        int n;
        n = 0;
        @(posedge CLK);
        repeat (3) @(posedge CLK);
        while (n < 151) begin
          @(posedge CLK);
          if (BCLK) n++;
        end
        #2;
        for (int k = 0; k < N + 1 && !BCLK; k++) begin
          @(posedge CLK);
          #2;
        end
        rx_ack = 1'b1;
        @(posedge CLK);
        #1 rx_ack = 1'b0;
      end
    join
    checkpoint("t6_ack_and_accept");
    check("t6_data_literal", rx_data, 8'h96);
    check("t6_no_overrun", ovr_cnt, 1);
    do_ack();

    //    baud skew of -3% and +3%
    send_frame(8'h12, 1'b1, BIT - 2, 1'b1);
    checkpoint("t6_fast");
    check("t6_fast_literal", rx_data, 8'h12);
    do_ack();
    send_frame(8'hED, 1'b1, BIT + 2, 1'b1);
    checkpoint("t6_slow");
    check("t6_slow_literal", rx_data, 8'hED);
    do_ack();
    checkpoint("final");
    check("final_frame_errors", fe_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
